// File: rtl/ysyx_24110006_imm_stage.sv
// rtl/ysyx_24110006_imm_stage.sv - RISC-V immediate decode feeding a DEPTH-entry output FIFO.
// Define YSYX_24110006_IMM_CSR_EN to decode CSR-immediate (zimm) instructions as fmt 7.
module ysyx_24110006_imm_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clock,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_inst,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_imm,
  output logic [2:0]               o_fmt,
  output logic [31:0]              o_inst,
  output logic [11:0]              o_csr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_U    = 3'd2;
  localparam logic [2:0] FMT_J    = 3'd3;
  localparam logic [2:0] FMT_S    = 3'd4;
  localparam logic [2:0] FMT_B    = 3'd5;
  localparam logic [2:0] FMT_R    = 3'd6;
  localparam logic [2:0] FMT_Z    = 3'd7;

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic [6:0]      opc;

  assign opc = i_inst[6:0];

  always_comb begin
    dec_fmt = FMT_NONE;
    case (opc)
      7'b0010011, 7'b1100111, 7'b0000011: dec_fmt = FMT_I;
      7'b1110011: begin
`ifdef YSYX_24110006_IMM_CSR_EN
        dec_fmt = i_inst[14] ? FMT_Z : FMT_I;
`else
        dec_fmt = FMT_I;
`endif
      end
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111:             dec_fmt = FMT_J;
      7'b0100011:             dec_fmt = FMT_S;
      7'b1100011:             dec_fmt = FMT_B;
      7'b0110011:             dec_fmt = FMT_R;
      7'b0011011:             dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      7'b0111011:             dec_fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
      default:                dec_fmt = FMT_NONE;
    endcase
  end

  // Signed size casts sign-extend each raw field to XLEN.
  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = XLEN'($signed(i_inst[31:20]));
      FMT_U: dec_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
      FMT_J: dec_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
      FMT_S: dec_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
      FMT_B: dec_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
      FMT_R: dec_imm = XLEN'(i_inst[31:25]);
      FMT_Z: dec_imm = XLEN'(i_inst[19:15]);
      default: dec_imm = '0;
    endcase
  end

  logic [XLEN-1:0] imm_q  [DEPTH];
  logic [2:0]      fmt_q  [DEPTH];
  logic [31:0]     inst_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign o_ready = (count_q != CW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (i_flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i]  <= '0;
        fmt_q[i]  <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push && !i_flush) begin
        imm_q[wr_q]  <= dec_imm;
        fmt_q[wr_q]  <= dec_fmt;
        inst_q[wr_q] <= i_inst;
      end
    end
  end

  // Payload is gated so an empty buffer presents all zeros.
  assign o_imm   = o_valid ? imm_q[rd_q]  : '0;
  assign o_fmt   = o_valid ? fmt_q[rd_q]  : '0;
  assign o_inst  = o_valid ? inst_q[rd_q] : '0;
  assign o_count = count_q;

`ifdef YSYX_24110006_IMM_CSR_EN
  assign o_csr = (o_valid && fmt_q[rd_q] == FMT_Z) ? inst_q[rd_q][31:20] : 12'd0;
`else
  assign o_csr = 12'd0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_imm_stage.sv
// tb/tb_ysyx_24110006_imm_stage.sv - directed checks of the immediate stage at XLEN 32 and 64.
module tb_ysyx_24110006_imm_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, flush, ready;
  logic [31:0] inst;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] imm32, inst32, inst64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [11:0] csr32, csr64;
  logic [1:0]  cnt32, cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24110006_imm_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .i_clock(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy32), .i_inst(inst),
    .i_flush(flush), .o_valid(vld32), .i_ready(ready), .o_imm(imm32), .o_fmt(fmt32),
    .o_inst(inst32), .o_csr(csr32), .o_count(cnt32)
  );

  ysyx_24110006_imm_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .i_clock(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy64), .i_inst(inst),
    .i_flush(flush), .o_valid(vld64), .i_ready(ready), .o_imm(imm64), .o_fmt(fmt64),
    .o_inst(inst64), .o_csr(csr64), .o_count(cnt64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] e_inst,
                            input logic [31:0] e_imm32, input logic [2:0] e_fmt32,
                            input logic [63:0] e_imm64, input logic [2:0] e_fmt64,
                            input logic [11:0] e_csr);
    check({tag, " v32"},    {63'd0, vld32}, 64'(e_inst != 32'd0));
    check({tag, " imm32"},  {32'd0, imm32}, {32'd0, e_imm32});
    check({tag, " fmt32"},  {61'd0, fmt32}, {61'd0, e_fmt32});
    check({tag, " inst32"}, {32'd0, inst32}, {32'd0, e_inst});
    check({tag, " csr32"},  {52'd0, csr32}, {52'd0, e_csr});
    check({tag, " imm64"},  imm64, e_imm64);
    check({tag, " fmt64"},  {61'd0, fmt64}, {61'd0, e_fmt64});
    check({tag, " inst64"}, {32'd0, inst64}, {32'd0, e_inst});
  endtask

  task automatic push_check(input string tag, input logic [31:0] w,
                            input logic [31:0] e_imm32, input logic [2:0] e_fmt32,
                            input logic [63:0] e_imm64, input logic [2:0] e_fmt64,
                            input logic [11:0] e_csr);
    valid = 1'b1;
    inst  = w;
    tick();
    check({tag, " cnt"}, {62'd0, cnt32}, 64'd1);
    check_head(tag, w, e_imm32, e_fmt32, e_imm64, e_fmt64, e_csr);
  endtask

  localparam logic [31:0] W_ADDI = 32'hFFF00093;
  localparam logic [31:0] W_LUI  = 32'h12345037;
  localparam logic [31:0] W_JAL  = 32'hFFDFF06F;
  localparam logic [31:0] W_BR   = 32'hFE000CE3;
  localparam logic [31:0] W_SW   = 32'hFE112E23;
  localparam logic [31:0] W_SUB  = 32'h40000033;
  localparam logic [31:0] W_CSR  = 32'h3002D073;
  localparam logic [31:0] W_IW   = 32'hFFF0809B;
  localparam logic [31:0] W_BAD  = 32'h0000007F;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    inst  = 32'd0;
    #1;
    check("rst cnt", {62'd0, cnt32}, 64'd0);
    check_head("rst", 32'd0, 32'd0, 3'd0, 64'd0, 3'd0, 12'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst ready32", {63'd0, rdy32}, 64'd1);
    check("post-rst ready64", {63'd0, rdy64}, 64'd1);

    ready = 1'b1;
    push_check("addi", W_ADDI, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 12'd0);
    push_check("lui",  W_LUI,  32'h12345000, 3'd2, 64'h0000000012345000, 3'd2, 12'd0);
    push_check("jal",  W_JAL,  32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 12'd0);
    push_check("beq",  W_BR,   32'hFFFFFFF8, 3'd5, 64'hFFFFFFFFFFFFFFF8, 3'd5, 12'd0);
    push_check("sw",   W_SW,   32'hFFFFFFFC, 3'd4, 64'hFFFFFFFFFFFFFFFC, 3'd4, 12'd0);
    push_check("sub",  W_SUB,  32'h00000020, 3'd6, 64'h0000000000000020, 3'd6, 12'd0);
`ifdef YSYX_24110006_IMM_CSR_EN
    push_check("csrwi", W_CSR, 32'h00000005, 3'd7, 64'h0000000000000005, 3'd7, 12'h300);
`else
    push_check("csrwi", W_CSR, 32'h00000300, 3'd1, 64'h0000000000000300, 3'd1, 12'd0);
`endif
    push_check("addiw", W_IW,  32'h00000000, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 12'd0);
    push_check("badop", W_BAD, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0, 12'd0);
    valid = 1'b0;
    tick();
    check("drain cnt", {62'd0, cnt32}, 64'd0);
    check_head("empty", 32'd0, 32'd0, 3'd0, 64'd0, 3'd0, 12'd0);

    // Backpressure: fill, hold a third word, then release.
    ready = 1'b0;
    valid = 1'b1;
    inst  = W_ADDI;
    tick();
    check("bp1 cnt", {62'd0, cnt32}, 64'd1);
    inst = W_LUI;
    tick();
    check("bp2 cnt", {62'd0, cnt32}, 64'd2);
    check("bp2 ready", {63'd0, rdy32}, 64'd0);
    check("bp2 head", {32'd0, inst32}, {32'd0, W_ADDI});
    inst = W_SW;
    tick();
    check("bp3 cnt", {62'd0, cnt32}, 64'd2);
    check("bp3 head", {32'd0, inst32}, {32'd0, W_ADDI});
    check("bp3 imm", {32'd0, imm32}, 64'hFFFFFFFF);
    ready = 1'b1;
    tick();
    check("bp4 cnt", {62'd0, cnt32}, 64'd1);
    check("bp4 head", {32'd0, inst32}, {32'd0, W_LUI});
    check("bp4 ready", {63'd0, rdy32}, 64'd1);
    tick();
    check("bp5 cnt", {62'd0, cnt32}, 64'd1);
    check_head("bp5", W_SW, 32'hFFFFFFFC, 3'd4, 64'hFFFFFFFFFFFFFFFC, 3'd4, 12'd0);
    valid = 1'b0;
    tick();
    check("bp6 cnt", {62'd0, cnt32}, 64'd0);

    // Flush beats a same-cycle push.
    ready = 1'b0;
    valid = 1'b1;
    inst  = W_ADDI;
    tick();
    check("fl1 cnt", {62'd0, cnt32}, 64'd1);
    flush = 1'b1;
    inst  = W_LUI;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    check("fl2 cnt", {62'd0, cnt32}, 64'd0);
    check_head("fl2", 32'd0, 32'd0, 3'd0, 64'd0, 3'd0, 12'd0);
    tick();
    check("fl3 cnt", {62'd0, cnt32}, 64'd0);
    check("fl3 inst", {32'd0, inst32}, 64'd0);

    // Asynchronous reset mid-cycle with two entries buffered.
    valid = 1'b1;
    inst  = W_JAL;
    tick();
    inst = W_BR;
    tick();
    valid = 1'b0;
    check("ar cnt", {62'd0, cnt32}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar valid", {63'd0, vld32}, 64'd0);
    check("ar imm32", {32'd0, imm32}, 64'd0);
    check("ar imm64", imm64, 64'd0);
    check("ar cnt0", {62'd0, cnt32}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar ready", {63'd0, rdy32}, 64'd1);
    check("ar cnt1", {62'd0, cnt64}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_imm_stage.md
YSYX_24110006_IMM_STAGE -- requirements
Module: ysyx_24110006_imm_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, legal values 32 or 64; sets the immediate width and enables RV64 opcodes when 64.
REQ-002 SHALL have parameter DEPTH, default 2, a power of two and at least 2; sets the number of output buffer entries.
REQ-003 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_valid  in  1  input instruction valid.
REQ-006 o_ready  out  1  stage can accept; equals !full; no combinational path from i_ready.
REQ-007 i_inst  in  32  instruction word.
REQ-008 i_flush  in  1  synchronous discard of all buffered entries.
REQ-009 o_valid  out  1  head entry valid.
REQ-010 i_ready  in  1  downstream accepts the head entry.
REQ-011 o_imm  out  XLEN  decoded immediate of the head entry.
REQ-012 o_fmt  out  3  format code: 0 none, 1 I, 2 U, 3 J, 4 S, 5 B, 6 R, 7 Z (CSR zimm).
REQ-013 o_inst  out  32  head instruction, passed through unchanged.
REQ-014 o_csr  out  12  CSR address of the head entry (inst[31:20]) when its fmt is 7; 0 otherwise.
REQ-015 o_count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Opcode classes SHALL be:
- I: 0010011, 1100111, 0000011, 1110011.
- U: 0110111, 0010111.
- J: 1101111.
- S: 0100011.
- B: 1100011.
- R: 0110011.
- When XLEN=64, additionally 0011011 is I and 0111011 is R.
- Any other opcode is none.
REQ-017 Immediates SHALL be:
- I: sign-extended inst[31:20].
- U: {inst[31:12], 12'b0}, sign-extended to XLEN.
- J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- S: sign-extended {inst[31:25], inst[11:7]}.
- B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- R: zero-extended inst[31:25].
- none: 0, fmt 0.
REQ-018 Decode SHALL be performed on the input side; the immediate, fmt, csr and inst SHALL be stored together in one entry.
REQ-019 A push SHALL occur when i_valid && o_ready; a pop SHALL occur when o_valid && i_ready.
REQ-020 Latency SHALL be 1 cycle: an entry pushed at edge N is presented with o_valid=1 after edge N.
REQ-021 Entries SHALL be popped in strict FIFO order; the read and write pointers wrap modulo DEPTH.
REQ-022 A push and a pop in the same cycle SHALL leave o_count unchanged.
REQ-023 Full (o_count==DEPTH) SHALL force o_ready=0; a pop while full frees the slot only after the edge.
REQ-024 When the buffer is empty, o_valid, o_imm, o_fmt, o_inst and o_csr SHALL all be 0.
REQ-025 i_flush SHALL clear o_count and both pointers at the next edge and take priority over a same-cycle push or pop; the pushed word is dropped.
REQ-026 Outputs SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-027 Asserting i_rst_n=0 SHALL immediately clear o_count, the pointers and all entry storage, and drive o_valid=0 and all payload outputs to 0, including mid-transfer.
REQ-028 o_ready SHALL be 1 from the first edge after reset release.

Configuration
REQ-029 With macro YSYX_24110006_IMM_CSR_EN defined, opcode 1110011 with inst[14]=1 SHALL produce fmt 7, o_imm = zero-extended inst[19:15], and o_csr = inst[31:20].
REQ-030 Without YSYX_24110006_IMM_CSR_EN, opcode 1110011 SHALL always be I-format and o_csr SHALL be tied to 0.

Verification
REQ-031 XLEN=32: push 0xFFF00093, 0x12345037, 0xFFDFF06F, 0xFE000CE3 back-to-back with i_ready=1 -> one cycle later o_imm = 0xFFFFFFFF/1, 0x12345000/2, 0xFFFFFFFC/3, 0xFFFFFFF8/5 (imm/fmt), in order.
REQ-032 With the macro, push 0x3002D073 -> o_imm=5, fmt 7, o_csr=0x300; without the macro -> o_imm=0x300, fmt 1, o_csr=0.
REQ-033 XLEN=64: push 0xFFF0809B -> o_imm=0xFFFFFFFFFFFFFFFF, fmt 1; push 0x0000007F -> o_imm=0, fmt 0.
REQ-034 DEPTH=2, i_ready=0, present 3 words -> o_ready=0 after 2 pushes, o_count=2, third word held; set i_ready=1 -> all 3 delivered in order, no loss or duplication.
REQ-035 With 1 entry buffered, assert i_flush together with a push -> next cycle o_count=0, o_valid=0; the pushed word never appears.
REQ-036 Pull i_rst_n low with 2 entries buffered, between edges -> o_valid and o_imm go to 0 without a clock edge; after release o_ready=1 and o_count=0.
